bit_stream_packer: RTL and testbench

Packs the single-bit stream produced by the `parameter_` stage into `WIDTH`-bit words. The block sits directly downstream of that stage and accepts one bit per valid/ready handshake, LSB first. It buffers completed words, each with an even-parity bit, in a small FIFO and presents them on a valid/ready output port. It is the first sequential stage after the combinational keyword-mangling modules.

---
 rtl/bit_stream_packer_pkg.sv | 24 ++
 rtl/bit_stream_packer_if.sv | 29 ++
 rtl/bit_stream_packer_fifo.sv | 58 +++++
 rtl/bit_stream_packer.sv | 91 +++++++++
 tb/tb_bit_stream_packer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_stream_packer_pkg.sv
// rtl/bit_stream_packer_pkg.sv - shared parameters, clog2 and FIFO entry layout for the bit packer
package packer_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 2;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // FIFO entry layout at the default width: parity sits above the data bits.
  // The top level declares the same {parity, bits} layout at its own WIDTH.
  typedef struct packed {
    logic                     parity;
    logic [WIDTH_DEFAULT-1:0] bits;
  } packer_entry_t;

endpackage

// File: rtl/bit_stream_packer_if.sv
// rtl/bit_stream_packer_if.sv - serial-in / word-out handshake bundle of the bit packer
interface bit_stream_packer_if
  import packer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic                  in_valid;
  logic                  in_bit;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_bits;
  logic                  out_parity;
  logic [clog2(WIDTH):0] bit_count;

  // Packer side: takes bits, offers words.
  modport master (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bits, out_parity, bit_count
  );

  // Environment side: upstream bit source plus downstream word consumer.
  modport slave (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bits, out_parity, bit_count
  );

endinterface

// File: rtl/bit_stream_packer_fifo.sv
// rtl/bit_stream_packer_fifo.sv - small pointer-based FIFO holding completed words with parity
module packer_fifo
  import packer_pkg::*;
#(
  parameter int DATA_W = WIDTH_DEFAULT + 1,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Flush wins over both ports; a pop frees the slot a same-edge push uses.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer registers, cleared by reset and flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bit_stream_packer.sv
// rtl/bit_stream_packer.sv - packs an LSB-first serial bit stream into parity-tagged words
module bit_stream_packer
  import packer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  bit_stream_packer_if.master bus
);

  localparam int CW = clog2(WIDTH) + 1;

  typedef struct packed {
    logic             parity;
    logic [WIDTH-1:0] bits;
  } entry_t;

  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    bit_count;
  logic             last_bit;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  entry_t           push_entry;
  entry_t           head_entry;

  // Only the completing bit can stall, and only when no slot frees this cycle.
  // The out_ready -> in_ready path is combinational on purpose.
  assign last_bit     = (bit_count == CW'(WIDTH - 1));
  assign bus.in_ready = !last_bit || !fifo_full || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && last_bit && !flush;
  assign pop          = bus.out_valid && bus.out_ready && !flush;

  // Drop the incoming bit into its position, giving the word as it stands after this accept.
  always_comb begin
    shift_next = shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_count == CW'(i)) shift_next[i] = bus.in_bit;
    end
  end

  assign push_entry = '{parity: ^shift_next, bits: shift_next};

  // Partial word and fill level; bit_count wraps to 0 on the completing bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift     <= '0;
      bit_count <= '0;
    end else if (flush) begin
      shift     <= '0;
      bit_count <= '0;
    end else if (accept) begin
      if (last_bit) begin
        shift     <= '0;
        bit_count <= '0;
      end else begin
        shift     <= shift_next;
        bit_count <= bit_count + CW'(1);
      end
    end
  end

  packer_fifo #(
    .DATA_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Idle output reads as zero rather than whatever sits in stale storage.
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_bits   = bus.out_valid ? head_entry.bits : '0;
  assign bus.out_parity = bus.out_valid & head_entry.parity;
  assign bus.bit_count  = bit_count;

endmodule

// File: tb/tb_bit_stream_packer.sv
// tb/tb_bit_stream_packer.sv - scoreboard bench for bit_stream_packer
module tb_bit_stream_packer;

  localparam int W = 8;

  logic clock;
  logic reset;
  logic flush;
  int   tests;
  int   fails;
  int   pops;

  logic [W:0]   sb[$];
  logic [W-1:0] model_shift;
  int           model_cnt;

  bit_stream_packer_if #(.WIDTH(W)) bus ();

  bit_stream_packer #(.WIDTH(W), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Consumer-side monitor: samples one time unit before each rising edge.
  always begin
    logic [W:0] exp;
    @(negedge clock);
    #4;
    if (reset && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      tests++;
      pops++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_word got=%h required=none", {bus.out_parity, bus.out_bits});
      end else begin
        exp = sb.pop_front();
        if ({bus.out_parity, bus.out_bits} !== exp) begin
          fails++;
          $display("FAIL sb_word got parity=%b bits=%h required parity=%b bits=%h",
                   bus.out_parity, bus.out_bits, exp[W], exp[W-1:0]);
        end
      end
    end
  end

  task automatic model_accept(input logic b);
    model_shift[model_cnt] = b;
    model_cnt++;
    if (model_cnt == W) begin
      sb.push_back({^model_shift, model_shift});
      model_cnt   = 0;
      model_shift = '0;
    end
  endtask

  task automatic model_clear();
    sb.delete();
    model_cnt   = 0;
    model_shift = '0;
  endtask

  task automatic set_ready(input int mode);
    if (mode == 0)      bus.out_ready = 1'b0;
    else if (mode == 1) bus.out_ready = 1'b1;
    else                bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one bit from the next falling edge; mode 0/1/2 = out_ready low/high/random.
  task automatic send_bit(input logic b, input int mode, output logic ready_first);
    int waited;
    waited = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    set_ready(mode);
    #1;
    ready_first = bus.in_ready;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clock);
      set_ready(mode);
      #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_bit_timeout in_ready=%b required=1", bus.in_ready);
    end else begin
      model_accept(b);
    end
  endtask

  task automatic send_word(input logic [W-1:0] word, input int mode);
    logic rf;
    for (int i = 0; i < W; i++) send_bit(word[i], mode, rf);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    @(negedge clock);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain words_left=%0d required=0", name, sb.size());
    end
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== '0 || bus.out_parity !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_zero valid=%b bits=%h parity=%b required 0/00/0",
               name, bus.out_valid, bus.out_bits, bus.out_parity);
    end
  endtask

  task automatic test_reset();
    logic rf;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== '0 || bus.out_parity !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.bit_count !== '0) begin
      fails++;
      $display("FAIL reset_initial valid=%b bits=%h parity=%b in_ready=%b count=%0d required 0/00/0/1/0",
               bus.out_valid, bus.out_bits, bus.out_parity, bus.in_ready, bus.bit_count);
    end
    @(negedge clock);
    reset = 1'b1;
    send_word(8'h81, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0, rf);
    idle();
    tests++;
    if (bus.bit_count !== 4'd5 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre count=%0d valid=%b required 5/1", bus.bit_count, bus.out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== '0 || bus.out_parity !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.bit_count !== '0) begin
      fails++;
      $display("FAIL reset_async valid=%b bits=%h parity=%b in_ready=%b count=%0d required 0/00/0/1/0",
               bus.out_valid, bus.out_bits, bus.out_parity, bus.in_ready, bus.bit_count);
    end
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.bit_count !== '0) begin
      fails++;
      $display("FAIL reset_release in_ready=%b count=%0d required 1/0", bus.in_ready, bus.bit_count);
    end
  endtask

  task automatic test_basic();
    logic rf;
    logic [W-1:0] pattern;
    pattern = 8'b0000_1101;
    for (int i = 0; i < W; i++) send_bit(pattern[i], 0, rf);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency out_valid=%b required=0", bus.out_valid);
    end
    idle();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_bits !== 8'h0D || bus.out_parity !== 1'b1 ||
        bus.bit_count !== '0) begin
      fails++;
      $display("FAIL basic_word valid=%b bits=%h parity=%b count=%0d required 1/0d/1/0",
               bus.out_valid, bus.out_bits, bus.out_parity, bus.bit_count);
    end
    drain("basic");
  endtask

  task automatic test_backpressure();
    logic rf;
    logic [W-1:0] third;
    int pops0;
    pops0 = pops;
    third = 8'h5A;
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    for (int i = 0; i < W - 1; i++) send_bit(third[i], 0, rf);
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_bit    = third[W-1];
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall in_ready=%b required=0", bus.in_ready);
    end
    @(negedge clock);
    #1;
    tests++;
    if (bus.in_ready !== 1'b0 || bus.bit_count !== 4'd7) begin
      fails++;
      $display("FAIL bp_hold in_ready=%b count=%0d required 0/7", bus.in_ready, bus.bit_count);
    end
    #1;
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release in_ready=%b required=1", bus.in_ready);
    end
    model_accept(third[W-1]);
    drain("bp");
    tests++;
    if (pops - pops0 != 3) begin
      fails++;
      $display("FAIL bp_pop_count got=%0d required=3", pops - pops0);
    end
  endtask

  task automatic test_full_push_pop();
    logic rf;
    logic [W-1:0] word;
    int pops0;
    int bad_ready;
    pops0 = pops;
    bad_ready = 0;
    send_word(8'h11, 0);
    send_word(8'hE7, 0);
    for (int w = 2; w < 16; w++) begin
      word = W'($urandom);
      for (int i = 0; i < W - 1; i++) send_bit(word[i], 0, rf);
      send_bit(word[W-1], 1, rf);
      if (rf !== 1'b1) bad_ready++;
    end
    tests++;
    if (bad_ready != 0) begin
      fails++;
      $display("FAIL full_pp_ready refused=%0d required=0", bad_ready);
    end
    word = 8'hC3;
    for (int i = 0; i < W - 1; i++) send_bit(word[i], 0, rf);
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_bit    = word[W-1];
    bus.out_ready = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL full_pp_still_full in_ready=%b valid=%b required 0/1", bus.in_ready, bus.out_valid);
    end
    #1;
    bus.out_ready = 1'b1;
    model_accept(word[W-1]);
    drain("full_pp");
    tests++;
    if (pops - pops0 != 17) begin
      fails++;
      $display("FAIL full_pp_pop_count got=%0d required=17", pops - pops0);
    end
  endtask

  task automatic test_flush();
    logic rf;
    logic [W-1:0] word;
    send_word(8'h3E, 0);
    send_bit(1'b1, 0, rf);
    send_bit(1'b1, 0, rf);
    send_bit(1'b0, 0, rf);
    idle();
    tests++;
    if (bus.bit_count !== 4'd3 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_pre count=%0d valid=%b required 3/1", bus.bit_count, bus.out_valid);
    end
    @(negedge clock);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    @(negedge clock);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.bit_count !== '0 || bus.out_valid !== 1'b0 || bus.out_bits !== '0) begin
      fails++;
      $display("FAIL flush_post count=%0d valid=%b bits=%h required 0/0/00",
               bus.bit_count, bus.out_valid, bus.out_bits);
    end
    model_clear();
    word = 8'h96;
    send_word(word, 0);
    idle();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_bits !== 8'h96 || bus.out_parity !== 1'b0) begin
      fails++;
      $display("FAIL flush_clean_word valid=%b bits=%h parity=%b required 1/96/0",
               bus.out_valid, bus.out_bits, bus.out_parity);
    end
    drain("flush");
  endtask

  task automatic test_wrap();
    int pops0;
    pops0 = pops;
    for (int w = 0; w < 10; w++) send_word(W'($urandom), 2);
    drain("wrap");
    tests++;
    if (pops - pops0 != 10) begin
      fails++;
      $display("FAIL wrap_pop_count got=%0d required=10", pops - pops0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pops  = 0;
    model_clear();
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_full_push_pop();
    test_flush();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
